// File: rtl/llc_mem_ctrl_pkg.sv
// Shared definitions for the LLC-side memory controller.
//   - FSM state encodings (kept as plain 2-bit constants so legacy
//     code that compares against raw values keeps working)
//   - line geometry: 128-bit line made of four 32-bit beats
package llc_mem_ctrl_pkg;

  localparam logic [1:0] LLC_ST_IDLE   = 2'd0;
  localparam logic [1:0] LLC_ST_ACCESS = 2'd1;
  localparam logic [1:0] LLC_ST_GAP    = 2'd2;
  localparam logic [1:0] LLC_ST_DONE   = 2'd3;

  localparam int LLC_LINE_W = 128;
  localparam int LLC_BEATS  = 4;

endpackage

// File: rtl/llc_mem_ctrl.sv
// LLC memory-side controller.
// Takes one 128-bit line read/write from the core's cache arbiter and
// serialises it into four 32-bit req/ack accesses on a word-wide backing
// memory (beat 0 = line bits [31:0]). Read lines are assembled into
// data_from_mem; completion is flagged on is_mem_ready.
//
// Ports
//   clk, rst            core clock, synchronous active-high reset
//   is_mem_req          core line request
//   is_memory_we        1 = line write, 0 = line read (sampled with request)
//   mem_addr_out[19:0]  line byte address (bits [3:0] ignored)
//   mem_data_out[127:0] write line (sampled with request)
//   is_mem_req_reset    core withdraws / acknowledges the request
//   data_from_mem       assembled read line
//   is_mem_ready        transfer complete
//   sram_req/we/addr/wdata, sram_rdata, sram_ack   backing-memory word port
//   busy                controller not idle
module llc_mem_ctrl
  import llc_mem_ctrl_pkg::*;
#(
  parameter int WORD_ADDR_W = 18,
  // Only 4 beats per line is supported; the beat counter is 2 bits wide.
  parameter int BEATS       = LLC_BEATS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   is_mem_req,
  input  logic                   is_memory_we,
  input  logic [19:0]            mem_addr_out,
  input  logic [LLC_LINE_W-1:0]  mem_data_out,
  input  logic                   is_mem_req_reset,
  output logic [LLC_LINE_W-1:0]  data_from_mem,
  output logic                   is_mem_ready,
  output logic                   sram_req,
  output logic                   sram_we,
  output logic [WORD_ADDR_W-1:0] sram_addr,
  output logic [31:0]            sram_wdata,
  input  logic [31:0]            sram_rdata,
  input  logic                   sram_ack,
  output logic                   busy
);

  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  logic [1:0]            st;
  logic [1:0]            beat;
  logic [15:0]           addr_q;
  logic [LLC_LINE_W-1:0] line_q;
  logic                  we_q;
  logic                  abort_q;
  logic [LLC_LINE_W-1:0] data_q;
  logic                  ready_q;
  logic                  abort;
  logic                  in_access;
  logic                  unused_addr_bits;

  // The line offset bits never reach the word port.
  assign unused_addr_bits = ^mem_addr_out[3:0];

  // The core drops or withdraws its request.
  assign abort     = is_mem_req_reset | ~is_mem_req;
  assign in_access = (st == LLC_ST_ACCESS);

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= LLC_ST_IDLE;
      beat    <= '0;
      addr_q  <= '0;
      line_q  <= '0;
      we_q    <= 1'b0;
      abort_q <= 1'b0;
      data_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      case (st)
        LLC_ST_IDLE: begin
          if (is_mem_req && !is_mem_req_reset) begin
            addr_q  <= mem_addr_out[19:4];
            line_q  <= mem_data_out;
            we_q    <= is_memory_we;
            beat    <= '0;
            abort_q <= 1'b0;
            st      <= LLC_ST_ACCESS;
          end
        end
        LLC_ST_ACCESS: begin
          // A read abort seen while waiting must survive until the ack,
          // even if the core releases it again in the meantime.
          if (!we_q && abort) abort_q <= 1'b1;
          if (sram_ack) begin
            if (!we_q) data_q[{beat, 5'b0} +: 32] <= sram_rdata;
            if (!we_q && (abort_q || abort)) begin
              st <= LLC_ST_IDLE;
            end else if (beat == LAST_BEAT) begin
              // Writes always finish all beats; only the ready report
              // depends on whether the abort is still held.
              if (we_q && abort) begin
                st <= LLC_ST_IDLE;
              end else begin
                st      <= LLC_ST_DONE;
                ready_q <= 1'b1;
              end
            end else begin
              beat <= beat + 2'd1;
              st   <= LLC_ST_GAP;
            end
          end
        end
        LLC_ST_GAP: begin
          // No access is outstanding here, so a read abort exits at once.
          if (!we_q && abort) st <= LLC_ST_IDLE;
          else                st <= LLC_ST_ACCESS;
        end
        default: begin
          if (abort) begin
            st      <= LLC_ST_IDLE;
            ready_q <= 1'b0;
          end
        end
      endcase
    end
  end

  // Word port is driven only in ACCESS and forced to zero otherwise.
  assign sram_req      = in_access;
  assign sram_we       = in_access & we_q;
  assign sram_addr     = in_access ? WORD_ADDR_W'({addr_q, beat}) : '0;
  assign sram_wdata    = in_access ? line_q[{beat, 5'b0} +: 32] : 32'd0;
  assign data_from_mem = data_q;
  assign is_mem_ready  = ready_q;
  assign busy          = (st != LLC_ST_IDLE);

endmodule

// File: tb/tb_llc_mem_ctrl.sv
// Directed bench for llc_mem_ctrl with a word-memory responder whose ack
// latency is programmable (0 = ack in the first request cycle).
module tb_llc_mem_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         is_mem_req;
  logic         is_memory_we;
  logic [19:0]  mem_addr_out;
  logic [127:0] mem_data_out;
  logic         is_mem_req_reset;
  logic [127:0] data_from_mem;
  logic         is_mem_ready;
  logic         sram_req;
  logic         sram_we;
  logic [17:0]  sram_addr;
  logic [31:0]  sram_wdata;
  logic [31:0]  sram_rdata;
  logic         sram_ack;
  logic         busy;

  int total = 0;
  int bad   = 0;
  int cyc;
  int ack_dly = 0;
  int cnt = 0;
  int unstable = 0;
  bit seen_ready;

  logic [31:0] mem [0:2047];
  logic [17:0] log_addr [$];
  logic        log_we   [$];
  logic [31:0] log_wd   [$];

  logic        p_req = 1'b0;
  logic        p_ack = 1'b0;
  logic        p_we  = 1'b0;
  logic [17:0] p_addr = '0;
  logic [31:0] p_wd   = '0;

  always #5 clk = ~clk;

  llc_mem_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .is_mem_req       (is_mem_req),
    .is_memory_we     (is_memory_we),
    .mem_addr_out     (mem_addr_out),
    .mem_data_out     (mem_data_out),
    .is_mem_req_reset (is_mem_req_reset),
    .data_from_mem    (data_from_mem),
    .is_mem_ready     (is_mem_ready),
    .sram_req         (sram_req),
    .sram_we          (sram_we),
    .sram_addr        (sram_addr),
    .sram_wdata       (sram_wdata),
    .sram_rdata       (sram_rdata),
    .sram_ack         (sram_ack),
    .busy             (busy)
  );

  // Responder: ack after ack_dly waiting cycles, combinational read data.
  assign sram_ack   = sram_req && (cnt == ack_dly);
  assign sram_rdata = mem[sram_addr[10:0]];

  always @(posedge clk) begin
    if (sram_req && !sram_ack) cnt <= cnt + 1;
    else                       cnt <= 0;
  end

  always @(posedge clk) begin
    if (rst) begin
      mem[11'h48C] <= 32'h11111111;
      mem[11'h48D] <= 32'h22222222;
      mem[11'h48E] <= 32'h33333333;
      mem[11'h48F] <= 32'h44444444;
    end else if (sram_req && sram_ack && sram_we) begin
      mem[sram_addr[10:0]] <= sram_wdata;
    end
  end

  always @(posedge clk) begin
    if (sram_req && sram_ack) begin
      log_addr.push_back(sram_addr);
      log_we.push_back(sram_we);
      log_wd.push_back(sram_wdata);
    end
  end

  // Word-port outputs must not move while an access waits for its ack.
  always @(posedge clk) begin
    if (sram_req && p_req && !p_ack &&
        (sram_addr !== p_addr || sram_wdata !== p_wd || sram_we !== p_we))
      unstable <= unstable + 1;
    p_req  <= sram_req;
    p_ack  <= sram_ack;
    p_we   <= sram_we;
    p_addr <= sram_addr;
    p_wd   <= sram_wdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_we.delete();
    log_wd.delete();
  endtask

  task automatic start_req(input logic we, input logic [19:0] a, input logic [127:0] d);
    is_mem_req   = 1'b1;
    is_memory_we = we;
    mem_addr_out = a;
    mem_data_out = d;
  endtask

  task automatic wait_ready(input int limit);
    while (!is_mem_ready && cyc < limit) begin
      tick();
      cyc++;
    end
  endtask

  task automatic release_req();
    is_mem_req       = 1'b0;
    is_mem_req_reset = 1'b0;
    tick();
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 128'(is_mem_ready), 128'd0);
    check({tag, "_busy"},  128'(busy), 128'd0);
    check({tag, "_req"},   128'(sram_req), 128'd0);
    check({tag, "_we"},    128'(sram_we), 128'd0);
    check({tag, "_addr"},  128'(sram_addr), 128'd0);
    check({tag, "_wdata"}, 128'(sram_wdata), 128'd0);
    check({tag, "_data"},  data_from_mem, 128'd0);
  endtask

  initial begin
    rst              = 1'b1;
    is_mem_req       = 1'b0;
    is_memory_we     = 1'b0;
    mem_addr_out     = '0;
    mem_data_out     = '0;
    is_mem_req_reset = 1'b0;
    tick(); tick(); tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Read line, ack in the request cycle.
    clear_log();
    ack_dly = 0;
    start_req(1'b0, 20'h01230, '0);
    cyc = 0;
    wait_ready(40);
    check("rd_latency", 128'(cyc), 128'd8);
    check("rd_nbeats", 128'(log_addr.size()), 128'd4);
    if (log_addr.size() == 4) begin
      check("rd_addr0", 128'(log_addr[0]), 128'h48C);
      check("rd_addr1", 128'(log_addr[1]), 128'h48D);
      check("rd_addr2", 128'(log_addr[2]), 128'h48E);
      check("rd_addr3", 128'(log_addr[3]), 128'h48F);
      check("rd_we3",   128'(log_we[3]),   128'd0);
    end
    check("rd_data", data_from_mem, 128'h44444444_33333333_22222222_11111111);
    check("rd_busy_done", 128'(busy), 128'd1);
    tick();
    check("rd_hold", data_from_mem, 128'h44444444_33333333_22222222_11111111);
    check("rd_ready_hold", 128'(is_mem_ready), 128'd1);
    is_mem_req = 1'b0;
    tick();
    check("rd_ready_drop", 128'(is_mem_ready), 128'd0);
    check("rd_idle", 128'(busy), 128'd0);
    tick();

    // Write line; core inputs scrambled after acceptance must not matter.
    clear_log();
    start_req(1'b1, 20'h00010, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF);
    tick();
    cyc = 1;
    mem_addr_out = 20'hFFFFF;
    mem_data_out = '1;
    is_memory_we = 1'b0;
    wait_ready(40);
    check("wr_latency", 128'(cyc), 128'd8);
    check("wr_nbeats", 128'(log_addr.size()), 128'd4);
    if (log_addr.size() == 4) begin
      check("wr_addr0",  128'(log_addr[0]), 128'h4);
      check("wr_addr3",  128'(log_addr[3]), 128'h7);
      check("wr_we0",    128'(log_we[0]),   128'd1);
      check("wr_we3",    128'(log_we[3]),   128'd1);
      check("wr_wd0",    128'(log_wd[0]),   128'h89ABCDEF);
      check("wr_wd1",    128'(log_wd[1]),   128'h01234567);
      check("wr_wd2",    128'(log_wd[2]),   128'hCAFEF00D);
      check("wr_wd3",    128'(log_wd[3]),   128'hDEADBEEF);
    end
    release_req();
    start_req(1'b0, 20'h00010, '0);
    cyc = 0;
    wait_ready(40);
    check("wr_readback", data_from_mem, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF);
    release_req();

    // Slow memory: ack three cycles after each request.
    ack_dly = 3;
    clear_log();
    start_req(1'b1, 20'h00020, 128'h0F0F0F0F_A5A5A5A5_5A5A5A5A_F0F0F0F0);
    cyc = 0;
    wait_ready(60);
    check("slow_latency", 128'(cyc), 128'd20);
    check("slow_stable", 128'(unstable), 128'd0);
    check("slow_mem8", 128'(mem[11'h008]), 128'hF0F0F0F0);
    check("slow_memB", 128'(mem[11'h00B]), 128'h0F0F0F0F);
    release_req();

    // Read aborted during beat 1.
    clear_log();
    start_req(1'b0, 20'h01230, '0);
    cyc = 0;
    while (!(sram_req && sram_addr == 18'h48D) && cyc < 30) begin
      tick();
      cyc++;
    end
    is_mem_req_reset = 1'b1;
    seen_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (is_mem_ready) seen_ready = 1'b1;
    end
    check("rab_ready", 128'(seen_ready), 128'd0);
    check("rab_nbeats", 128'(log_addr.size()), 128'd2);
    if (log_addr.size() == 2) check("rab_last", 128'(log_addr[1]), 128'h48D);
    check("rab_busy", 128'(busy), 128'd0);
    check("rab_req", 128'(sram_req), 128'd0);
    release_req();

    // Write aborted during beat 0 still writes the whole line.
    ack_dly = 1;
    clear_log();
    start_req(1'b1, 20'h00030, 128'h13579BDF_2468ACE0_FEDCBA98_76543210);
    tick();
    is_mem_req_reset = 1'b1;
    seen_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (is_mem_ready) seen_ready = 1'b1;
    end
    check("wab_ready", 128'(seen_ready), 128'd0);
    check("wab_nbeats", 128'(log_addr.size()), 128'd4);
    check("wab_memC", 128'(mem[11'h00C]), 128'h76543210);
    check("wab_memD", 128'(mem[11'h00D]), 128'hFEDCBA98);
    check("wab_memE", 128'(mem[11'h00E]), 128'h2468ACE0);
    check("wab_memF", 128'(mem[11'h00F]), 128'h13579BDF);
    check("wab_busy", 128'(busy), 128'd0);
    release_req();

    // Request and withdraw together in IDLE: nothing starts.
    is_mem_req       = 1'b1;
    is_mem_req_reset = 1'b1;
    tick(); tick(); tick();
    check("both_busy", 128'(busy), 128'd0);
    check("both_req", 128'(sram_req), 128'd0);
    release_req();

    // Reset while in DONE.
    ack_dly = 0;
    start_req(1'b0, 20'h01230, '0);
    cyc = 0;
    wait_ready(40);
    check("rstd_ready_before", 128'(is_mem_ready), 128'd1);
    rst        = 1'b1;
    is_mem_req = 1'b0;
    tick();
    check_all_zero("rst_done");
    rst = 1'b0;
    tick();

    // Reset in the middle of an access.
    ack_dly = 3;
    start_req(1'b1, 20'h00040, 128'h1);
    tick(); tick();
    check("rsta_req_before", 128'(sram_req), 128'd1);
    rst        = 1'b1;
    is_mem_req = 1'b0;
    tick();
    check_all_zero("rst_access");
    rst = 1'b0;
    tick();

    // Fresh read completes normally after reset.
    ack_dly = 0;
    start_req(1'b0, 20'h01230, '0);
    cyc = 0;
    wait_ready(40);
    check("post_latency", 128'(cyc), 128'd8);
    check("post_data", data_from_mem, 128'h44444444_33333333_22222222_11111111);
    release_req();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/llc_mem_ctrl.md
Name: llc_mem_ctrl

Overview:
- Memory-side controller directly downstream of the Elpis core's LLC port.
- Accepts one 128-bit cache-line read or write request from the core's icache/dcache arbiter.
- Serialises each line into four 32-bit accesses on a word-wide backing memory with a req/ack handshake.
- Returns read lines on data_from_mem and signals completion with is_mem_ready.

Parameters:
- WORD_ADDR_W, 18, width of the backing-memory word address (20-bit byte address minus 2 offset bits).
- BEATS, 4, 32-bit beats per line; fixed at 4, any other value is unsupported.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous, active-high reset
- is_mem_req  input  1  core requests a line transfer
- is_memory_we  input  1  1 = line write, 0 = line read; sampled with the request
- mem_addr_out  input  20  line byte address from the core; bits [3:0] ignored
- mem_data_out  input  128  write line from the core; sampled with the request
- is_mem_req_reset  input  1  core withdraws or acknowledges the request
- data_from_mem  output  128  read line returned to the core
- is_mem_ready  output  1  transfer complete
- sram_req  output  1  word access request to the backing memory
- sram_we  output  1  word write enable
- sram_addr  output  WORD_ADDR_W  word address
- sram_wdata  output  32  write word
- sram_rdata  input  32  read word; valid when sram_ack=1
- sram_ack  input  1  one-cycle acknowledge of the current word access
- busy  output  1  state is not IDLE (debug/perf counter)

Behaviour:
- Reset: synchronous. State=IDLE. All outputs are 0, including data_from_mem. beat=0. The latched address, data and we registers are cleared.
- IDLE:
  - If is_mem_req=1 and is_mem_req_reset=0: latch addr[19:4], the write line and we.
  - beat<=0, go to ACCESS.
  - Request acceptance costs 1 cycle; sram_req rises in the following cycle.
- ACCESS:
  - sram_req=1.
  - sram_addr = {addr[19:4], beat[1:0]}, zero-extended to WORD_ADDR_W.
  - sram_we = latched we.
  - sram_wdata = line[32*beat +: 32]. Beat 0 is bits [31:0]; little-endian word order.
  - Outputs are held stable until sram_ack.
  - On sram_ack, a read stores sram_rdata into data_from_mem[32*beat +: 32].
  - On sram_ack with beat==3, go to DONE. Otherwise beat<=beat+1 and sram_req is dropped for exactly one cycle (GAP), then return to ACCESS.
  - sram_ack arriving outside ACCESS is ignored.
- DONE:
  - is_mem_ready=1 and data_from_mem is held stable.
  - Stay in DONE until is_mem_req_reset=1 or is_mem_req=0, then go to IDLE. is_mem_ready drops in that same transition cycle (registered, so it is low on the next cycle).
  - A new request cannot start in the cycle DONE exits; the minimum request spacing is 1 IDLE cycle.
- Minimum latency, request edge to is_mem_ready: 1 + 4 (ack in the same cycle as req) + 3 gap cycles = 8 cycles.
- Abort (is_mem_req_reset=1 or is_mem_req=0 during ACCESS/GAP):
  - Read: finish the outstanding word access (wait for its ack), then go to IDLE without asserting is_mem_ready. data_from_mem is partially updated and undefined to the core.
  - Write: ignore the abort and complete all 4 beats so backing lines are never torn; then go to IDLE, not DONE, if the abort is still active, otherwise go to DONE.
- Simultaneous is_mem_req=1 and is_mem_req_reset=1 in IDLE: no request is accepted.
- The request and the latched inputs are not re-sampled mid-transfer; core changes to mem_addr_out or mem_data_out during a transfer have no effect.
- busy=1 in ACCESS, GAP and DONE.

Decomposition:
- Shared definitions include gains these constants:
  - LLC_ST_IDLE=2'd0, LLC_ST_ACCESS=2'd1, LLC_ST_GAP=2'd2, LLC_ST_DONE=2'd3
  - LLC_LINE_W=128, LLC_BEATS=4
- Single module; no sub-module. The beat-to-slice mux is inline.

Test Plan:
- Read line at addr 20'h01230; memory words at word addresses 0x48C..0x48F = 11111111, 22222222, 33333333, 44444444; ack in same cycle -> sram_addr sequence 0x48C, 0x48D, 0x48E, 0x48F; is_mem_ready rises 8 cycles after the req edge; data_from_mem = 128'h44444444_33333333_22222222_11111111.
- Write line 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF to addr 20'h00010 -> sram_we=1 on 4 beats to word addresses 4..7 with wdata 89ABCDEF, 01234567, CAFEF00D, DEADBEEF; is_mem_ready=1; a read-back returns the same line.
- Memory ack delayed 3 cycles per beat -> sram_req/addr/wdata stable while waiting; is_mem_ready after 1+4*4+3 = 20 cycles.
- Read aborted by is_mem_req_reset during beat 1 -> beat 1 completes, no further sram_req, is_mem_ready never asserts, state is IDLE and busy=0.
- Write aborted during beat 0 -> all 4 words written, is_mem_ready stays 0, returns to IDLE.
- rst asserted in DONE and again mid-ACCESS -> next cycle all outputs 0 and state IDLE; a fresh request afterwards completes normally.
